// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states
// and op-code legality helper.
package alu_pkg;

    // ALU op codes as seen on in_op / alu_select
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLA  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_LAST = 4'd8;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Op codes above OP_LAST have no ALU function behind them
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        if (op <= OP_LAST) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_imm_extend.sv
// Immediate extension for the second ALU operand. Logical ops see the
// immediate zero-extended, shifts only use the low five bits as a shift
// amount, everything else (arithmetic and unknown ops) is sign-extended.
module imm_extend
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [15:0]      imm,
    output logic [WIDTH-1:0] ext
);

    // Select the extension flavour from the op code
    always_comb begin
        ext = '0;
        case (op)
            OP_AND, OP_OR, OP_XOR: begin
                ext = WIDTH'(imm);
            end
            OP_SLA, OP_SRA, OP_SRL: begin
                ext = WIDTH'(imm[4:0]);
            end
            default: begin
                ext = WIDTH'($signed(imm));
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle execute sequencer wrapped around an external combinational
// ALU. Accepts one instruction in IDLE, holds the ALU inputs for
// EXEC_CYCLES cycles, captures the result with zero/negative flags and
// presents it to writeback until it is taken.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [15:0]      in_imm,
    input  logic             in_use_imm,
    input  logic [4:0]       in_dest,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_dest,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_illegal
);

    // The counter counts down to zero; the capture happens on the edge
    // where it reads zero, so it is loaded with EXEC_CYCLES-1.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e           state_r;
    logic [3:0]       cnt_r;
    logic [4:0]       dest_r;
    logic [WIDTH-1:0] ext_s;
    logic [WIDTH-1:0] opnd2_s;
    logic [WIDTH-1:0] result_s;
    logic             illegal_s;
    logic             zero_s;
    logic             neg_s;

    imm_extend #(
        .WIDTH (WIDTH)
    ) u_imm_extend (
        .op  (in_op),
        .imm (in_imm),
        .ext (ext_s)
    );

    // Ready is a plain decode of the state register
    assign in_ready = (state_r == ST_IDLE);

    // Second operand comes from the immediate or from rt
    always_comb begin
        opnd2_s = in_rt;
        if (in_use_imm) begin
            opnd2_s = ext_s;
        end else begin
            opnd2_s = in_rt;
        end
    end

    // Value and flags to capture: illegal ops force a zero result
    always_comb begin
        illegal_s = !is_legal_op(alu_select);
        result_s  = '0;
        if (illegal_s) begin
            result_s = '0;
        end else begin
            result_s = alu_out;
        end
        zero_s = (result_s == '0);
        neg_s  = result_s[WIDTH-1];
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            dest_r      <= 5'd0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_select  <= 4'd0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_dest    <= 5'd0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_in1    <= in_rs;
                        alu_in2    <= opnd2_s;
                        alu_select <= in_op;
                        dest_r     <= in_dest;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= ST_EXEC;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == 4'd0) begin
                        out_result  <= result_s;
                        out_dest    <= dest_r;
                        out_zero    <= zero_s;
                        out_neg     <= neg_s;
                        out_illegal <= illegal_s;
                        out_valid   <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r       <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1 and
// one with EXEC_CYCLES=3, each with a behavioural ALU on its ALU port.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid3 = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_rs = 32'd0;
    logic [31:0] in_rt = 32'd0;
    logic [15:0] in_imm = 16'd0;
    logic        in_use_imm = 1'b0;
    logic [4:0]  in_dest = 5'd0;
    logic        out_ready = 1'b0;
    logic        out_ready3 = 1'b0;

    logic        in_ready, out_valid, out_zero, out_neg, out_illegal;
    logic [31:0] alu_in1, alu_in2, alu_out, out_result;
    logic [3:0]  alu_select;
    logic [4:0]  out_dest;

    logic        in_ready3, out_valid3, out_zero3, out_neg3, out_illegal3;
    logic [31:0] alu_in1_3, alu_in2_3, alu_out3, out_result3;
    logic [3:0]  alu_select3;
    logic [4:0]  out_dest3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_in1, alu_in2, alu_select);
    assign alu_out3 = alu_f(alu_in1_3, alu_in2_3, alu_select3);

    alu_issue_ctrl #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_dest(in_dest),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_zero(out_zero), .out_neg(out_neg), .out_illegal(out_illegal)
    );

    alu_issue_ctrl #(.WIDTH(32), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_dest(in_dest),
        .alu_in1(alu_in1_3), .alu_in2(alu_in2_3), .alu_select(alu_select3), .alu_out(alu_out3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
        .out_dest(out_dest3), .out_zero(out_zero3), .out_neg(out_neg3), .out_illegal(out_illegal3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction to the first instance for exactly one edge
    task automatic send(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic use_imm, input logic [4:0] dest);
        in_op = op; in_rs = rs; in_rt = rt; in_imm = imm; in_use_imm = use_imm; in_dest = dest;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (alu_in1 !== 32'd0) begin errors++; $display("FAIL rst_alu_in1 got=%h exp=0", alu_in1); end
        checks++; if (alu_select !== 4'd0) begin errors++; $display("FAIL rst_alu_select got=%h exp=0", alu_select); end
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL rst_out_result got=%h exp=0", out_result); end
        checks++; if (out_illegal !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", out_illegal, out_zero); end
        rst_n = 1'b1; rst3_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        send(4'd0, 32'd5, 32'd7, 16'd0, 1'b0, 5'd3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_mid got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early got=%b exp=0", out_valid); end
        checks++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin errors++; $display("FAIL add_alu_in got=%h,%h exp=5,7", alu_in1, alu_in2); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=c", out_result); end
        checks++; if (out_zero !== 1'b0 || out_neg !== 1'b0) begin errors++; $display("FAIL add_flags got=z%b n%b exp=z0 n0", out_zero, out_neg); end
        checks++; if (out_dest !== 5'd3) begin errors++; $display("FAIL add_dest got=%0d exp=3", out_dest); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_done got=%b exp=0", in_ready); end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_drain got=v%b r%b exp=v0 r1", out_valid, in_ready); end
    endtask

    task automatic test_imm_sext();
        send(4'd1, 32'd3, 32'd99, 16'h0004, 1'b1, 5'd4);
        checks++; if (alu_in2 !== 32'd4) begin errors++; $display("FAIL sub_imm_in2 got=%h exp=4", alu_in2); end
        tick();
        checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_result got=%h exp=ffffffff", out_result); end
        checks++; if (out_neg !== 1'b1 || out_zero !== 1'b0) begin errors++; $display("FAIL sub_flags got=n%b z%b exp=n1 z0", out_neg, out_zero); end
        drain();
        send(4'd0, 32'd0, 32'd0, 16'hFFFE, 1'b1, 5'd5);
        checks++; if (alu_in2 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_sext_in2 got=%h exp=fffffffe", alu_in2); end
        tick();
        checks++; if (out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_sext_result got=%h exp=fffffffe", out_result); end
        drain();
    endtask

    task automatic test_logic_shift();
        send(4'd3, 32'd0, 32'd0, 16'h8000, 1'b1, 5'd6);
        checks++; if (alu_in2 !== 32'h0000_8000) begin errors++; $display("FAIL or_zext_in2 got=%h exp=00008000", alu_in2); end
        tick();
        checks++; if (out_result !== 32'h0000_8000 || out_neg !== 1'b0) begin errors++; $display("FAIL or_result got=%h n%b exp=00008000 n0", out_result, out_neg); end
        drain();
        send(4'd8, 32'h8000_0000, 32'd0, 16'hFFE4, 1'b1, 5'd7);
        checks++; if (alu_in2 !== 32'd4) begin errors++; $display("FAIL srl_in2 got=%h exp=4", alu_in2); end
        tick();
        checks++; if (out_result !== 32'h0800_0000) begin errors++; $display("FAIL srl_result got=%h exp=08000000", out_result); end
        drain();
        send(4'd7, 32'h8000_0000, 32'd0, 16'h0004, 1'b1, 5'd8);
        tick();
        checks++; if (out_result !== 32'hF800_0000 || out_neg !== 1'b1) begin errors++; $display("FAIL sra_result got=%h n%b exp=f8000000 n1", out_result, out_neg); end
        drain();
        send(4'd2, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 16'h0000, 1'b0, 5'd9);
        tick();
        checks++; if (out_result !== 32'h0F0F_0F0F) begin errors++; $display("FAIL and_result got=%h exp=0f0f0f0f", out_result); end
        drain();
        send(4'd4, 32'h1234_5678, 32'h1234_5678, 16'h0000, 1'b0, 5'd10);
        tick();
        checks++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_illegal !== 1'b0) begin errors++; $display("FAIL xor_zero got=%h z%b i%b exp=0 z1 i0", out_result, out_zero, out_illegal); end
        drain();
    endtask

    task automatic test_backpressure();
        send(4'd0, 32'd1, 32'd1, 16'd0, 1'b0, 5'd9);
        tick();
        in_op = 4'd4; in_rs = 32'h0000_00AA; in_rt = 32'd0; in_dest = 5'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_dest !== 5'd9) begin errors++; $display("FAIL bp_hold[%0d] got=v%b %h d%0d exp=v1 2 d9", i, out_valid, out_result, out_dest); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            checks++; if (alu_in1 !== 32'd1 || alu_select !== 4'd0) begin errors++; $display("FAIL bp_no_accept[%0d] got=%h sel%h exp=1 sel0", i, alu_in1, alu_select); end
            tick();
        end
        in_valid = 1'b0;
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        checks++; if (alu_in1 !== 32'd1) begin errors++; $display("FAIL bp_alu_hold got=%h exp=1", alu_in1); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_ignored got=v%b r%b exp=v0 r1", out_valid, in_ready); end
    endtask

    task automatic test_illegal();
        send(4'd12, 32'd5, 32'd7, 16'd0, 1'b0, 5'd11);
        checks++; if (alu_select !== 4'd12) begin errors++; $display("FAIL ill_select got=%0d exp=12", alu_select); end
        tick();
        checks++; if (out_illegal !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1) begin errors++; $display("FAIL ill_capture got=i%b %h z%b exp=i1 0 z1", out_illegal, out_result, out_zero); end
        drain();
    endtask

    task automatic test_exec3_reset();
        int lat;
        in_op = 4'd1; in_rs = 32'd10; in_rt = 32'd4; in_use_imm = 1'b0; in_dest = 5'd13;
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        lat = 0;
        while (out_valid3 !== 1'b1 && lat < 20) begin
            checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL e3_in_ready got=%b exp=0", in_ready3); end
            tick();
            lat++;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL e3_latency got=%0d exp=3", lat); end
        checks++; if (out_result3 !== 32'd6 || out_dest3 !== 5'd13) begin errors++; $display("FAIL e3_result got=%h d%0d exp=6 d13", out_result3, out_dest3); end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        in_op = 4'd0; in_rs = 32'd5; in_rt = 32'd7;
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        rst3_n = 1'b0;
        tick();
        rst3_n = 1'b1;
        checks++; if (out_valid3 !== 1'b0 || out_result3 !== 32'd0 || out_dest3 !== 5'd0) begin errors++; $display("FAIL e3_rst_out got=v%b %h d%0d exp=v0 0 d0", out_valid3, out_result3, out_dest3); end
        checks++; if (alu_in1_3 !== 32'd0 || alu_in2_3 !== 32'd0 || alu_select3 !== 4'd0) begin errors++; $display("FAIL e3_rst_alu got=%h %h %h exp=0 0 0", alu_in1_3, alu_in2_3, alu_select3); end
        checks++; if (out_zero3 !== 1'b0 || out_neg3 !== 1'b0 || out_illegal3 !== 1'b0) begin errors++; $display("FAIL e3_rst_flags got=%b%b%b exp=000", out_zero3, out_neg3, out_illegal3); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin errors++; $display("FAIL e3_abandon[%0d] got=v%b r%b exp=v0 r1", k, out_valid3, in_ready3); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_sext();
        test_logic_shift();
        test_backpressure();
        test_illegal();
        test_exec3_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
